gandhi_pose_sequencer: RTL and testbench
========================================

Name: gandhi_pose_sequencer

Overview:
Upstream stage of the Gandhi sprite controller. It generates that controller's `looking_up` select from manual up/down requests and an optional automatic up/down cycle. Pose changes are committed only at a frame boundary inside vertical blanking, so the sprite never switches ROMs mid-frame. The block runs on the pixel clock and takes the same hCount/vCount as the sprite controller.

Parameters:
- H_TRIG, 0: hCount value of the frame-boundary trigger point.
- V_TRIG, 480: vCount value of the trigger point (first blanking line).
- UP_FRAMES, 30: frames the pose stays up before it automatically returns down; must be ≥ 1.
- DOWN_FRAMES, 90: frames spent down before an automatic look-up when auto_en = 1; must be ≥ 1.
- CNT_W, 8: frame counter width; must hold max(UP_FRAMES, DOWN_FRAMES) − 1.

Ports:
- clk  in  1  pixel clock (same clock as the hCount/vCount source)
- rst  in  1  asynchronous, active-high reset
- hCount  in  10  current horizontal pixel count
- vCount  in  10  current vertical line count
- req_up  in  1  one-cycle request to look up
- req_down  in  1  one-cycle request to look down
- auto_en  in  1  level; enables the automatic down→up cycle
- looking_up  out  1  registered pose select: 1 = up, 0 = down
- frame_tick  out  1  registered one-cycle pulse per frame boundary
- pose_changed  out  1  registered one-cycle pulse in the first cycle looking_up holds a new value

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high. While rst = 1:
  - looking_up = 0, frame_tick = 0, pose_changed = 0
  - state = DOWN, frame_cnt = 0
- frame_tick:
  - match = (hCount == H_TRIG) && (vCount == V_TRIG).
  - frame_tick asserts on the clock edge after the first cycle of match, using a rising-edge detect on match.
  - It is exactly one cycle wide even if match holds for several cycles, and fires once per frame.
- State machine (all transitions evaluate the registered frame_tick):
  - DOWN (looking_up = 0):
    - If auto_en = 0: frame_cnt is cleared and held at 0.
    - If auto_en = 1: frame_cnt increments on each tick.
    - On a tick with auto_en = 1 and frame_cnt == DOWN_FRAMES − 1: go to UP, set looking_up = 1, frame_cnt = 0.
    - req_up (without req_down): go to ARM_UP. This is evaluated before the tick rule, so a request in the same cycle as a tick still waits for the next tick.
  - ARM_UP (looking_up = 0):
    - On a tick: go to UP, looking_up = 1, frame_cnt = 0.
    - req_down cancels: go to DOWN, frame_cnt = 0, no pose change.
    - req_up has no effect.
  - UP (looking_up = 1):
    - frame_cnt increments on each tick, independent of auto_en.
    - On a tick with frame_cnt == UP_FRAMES − 1: go to DOWN, looking_up = 0, frame_cnt = 0.
    - req_up restarts the hold: frame_cnt = 0.
    - req_down: go to ARM_DOWN.
  - ARM_DOWN (looking_up = 1):
    - On a tick: go to DOWN, looking_up = 0, frame_cnt = 0.
    - req_up cancels: go to UP, frame_cnt = 0.
- pose_changed asserts for exactly one cycle, in the same cycle that looking_up first shows its new value. It never asserts when a request is cancelled.
- If req_up and req_down are both asserted in one cycle, req_down wins: it is treated as req_down alone.
- A request arriving in the same cycle as a tick is taken as the state change only. The arming transition takes priority over the tick.
- Latency from request to pose change:
  - minimum: 1 cycle (request lands in the cycle just before a tick)
  - maximum: 1 frame + 1 cycle
- frame_cnt never wraps: every path that reaches the limit leaves the state and clears the counter.
- Reset asserted mid-operation returns everything to the reset values immediately, with no pose_changed pulse. After release, the first tick is produced by the next rising edge of match.
- Parameter rule: UP_FRAMES = 1 means the pose is up for exactly one frame.

Test Plan:
All scenarios use UP_FRAMES = 2, DOWN_FRAMES = 3 and a full 800×525 scan.
1. Reset / tick width: hold rst, then release with auto_en = 0 → looking_up = 0 and no pose_changed. frame_tick is one cycle, once per 420000 clocks, one cycle after (hCount, vCount) = (0, 480) is seen.
2. Manual up with timeout: pulse req_up at vCount = 100 → looking_up rises at the next tick (+1 cycle) together with a one-cycle pose_changed. It falls 2 ticks later, again with pose_changed.
3. Auto cycle: auto_en = 1 → looking_up is 0 for 3 frames, then 1 for 2 frames, and repeats. pose_changed fires at every edge of looking_up and nowhere else.
4. Cancel / conflict:
   - req_up, then req_down before the tick → looking_up stays 0 and no pose_changed.
   - req_up and req_down in the same cycle while in DOWN → no change.
   - In UP: req_down, then req_up before the tick → looking_up stays 1 and the hold restarts at 0.
5. Tick collision: req_up in the exact cycle frame_tick = 1 → no change at that tick; looking_up rises at the following tick.
6. Reset mid-hold: assert rst while in UP with frame_cnt = 1 → looking_up = 0 asynchronously, pose_changed = 0, and the automatic cycle restarts from DOWN after release.

Source files
------------

// File: rtl/gandhi_pose_sequencer.sv
// Pose sequencer for the Gandhi sprite: turns up/down requests and an optional
// automatic cycle into a looking_up select that only changes at a frame boundary.
module gandhi_pose_sequencer #(
  parameter int H_TRIG      = 0,
  parameter int V_TRIG      = 480,
  parameter int UP_FRAMES   = 30,
  parameter int DOWN_FRAMES = 90,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       req_up,
  input  logic       req_down,
  input  logic       auto_en,
  output logic       looking_up,
  output logic       frame_tick,
  output logic       pose_changed
);

  typedef enum logic [1:0] {
    DOWN     = 2'd0,
    ARM_UP   = 2'd1,
    UP       = 2'd2,
    ARM_DOWN = 2'd3
  } state_t;

  localparam logic [9:0]       H_TRIG_V  = 10'(H_TRIG);
  localparam logic [9:0]       V_TRIG_V  = 10'(V_TRIG);
  localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(UP_FRAMES - 1);
  localparam logic [CNT_W-1:0] DOWN_LAST = CNT_W'(DOWN_FRAMES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             match;
  logic             match_q, match_d;
  logic             frame_tick_q, frame_tick_d;
  logic             looking_up_q, looking_up_d;
  logic             pose_changed_q, pose_changed_d;
  logic             eff_up, eff_down;

  assign match = (hCount == H_TRIG_V) && (vCount == V_TRIG_V);

  // A simultaneous up+down request collapses to down alone.
  assign eff_down = req_down;
  assign eff_up   = req_up && !req_down;

  always_comb begin
    match_d      = match;
    frame_tick_d = match && !match_q;
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;

    // Requests are checked before the tick so that arming or cancelling
    // always wins over a boundary landing in the same cycle.
    case (state_q)
      DOWN: begin
        if (eff_up) begin
          state_d     = ARM_UP;
          frame_cnt_d = '0;
        end else if (!auto_en) begin
          frame_cnt_d = '0;
        end else if (frame_tick_q) begin
          if (frame_cnt_q == DOWN_LAST) begin
            state_d     = UP;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      ARM_UP: begin
        if (eff_down) begin
          state_d     = DOWN;
          frame_cnt_d = '0;
        end else if (frame_tick_q) begin
          state_d     = UP;
          frame_cnt_d = '0;
        end
      end
      UP: begin
        if (eff_down) begin
          state_d = ARM_DOWN;
        end else if (eff_up) begin
          frame_cnt_d = '0;
        end else if (frame_tick_q) begin
          if (frame_cnt_q == UP_LAST) begin
            state_d     = DOWN;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      ARM_DOWN: begin
        if (eff_up) begin
          state_d     = UP;
          frame_cnt_d = '0;
        end else if (frame_tick_q) begin
          state_d     = DOWN;
          frame_cnt_d = '0;
        end
      end
      default: begin
        state_d     = DOWN;
        frame_cnt_d = '0;
      end
    endcase

    // The pose follows the state; armed states still show the old pose.
    looking_up_d   = (state_d == UP) || (state_d == ARM_DOWN);
    pose_changed_d = looking_up_d != looking_up_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= DOWN;
      frame_cnt_q    <= '0;
      match_q        <= 1'b0;
      frame_tick_q   <= 1'b0;
      looking_up_q   <= 1'b0;
      pose_changed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      match_q        <= match_d;
      frame_tick_q   <= frame_tick_d;
      looking_up_q   <= looking_up_d;
      pose_changed_q <= pose_changed_d;
    end
  end

  assign looking_up   = looking_up_q;
  assign frame_tick   = frame_tick_q;
  assign pose_changed = pose_changed_q;

endmodule

// File: tb/tb_gandhi_pose_sequencer.sv
// Directed bench for gandhi_pose_sequencer with a compressed frame: only the
// scan positions around the trigger point are driven, one trigger per frame.
module tb_gandhi_pose_sequencer;

  logic       clk;
  logic       rst;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       reqUp;
  logic       reqDown;
  logic       autoEn;
  logic       lookingUp;
  logic       frameTick;
  logic       poseChanged;

  int totalChecks;
  int badChecks;
  int tickCount;
  int changeCount;

  gandhi_pose_sequencer #(
    .H_TRIG(0),
    .V_TRIG(480),
    .UP_FRAMES(2),
    .DOWN_FRAMES(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hCount(hCount),
    .vCount(vCount),
    .req_up(reqUp),
    .req_down(reqDown),
    .auto_en(autoEn),
    .looking_up(lookingUp),
    .frame_tick(frameTick),
    .pose_changed(poseChanged)
  );

  // Free-running pixel clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the run ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input int got, input int exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns just after the edge that sampled them
  task automatic applyStimulus(input int h, input int v, input logic up, input logic dn);
    hCount  = 10'(h);
    vCount  = 10'(v);
    reqUp   = up;
    reqDown = dn;
    @(posedge clk);
    #1;
    reqUp   = 1'b0;
    reqDown = 1'b0;
    if (frameTick === 1'b1) tickCount++;
    if (poseChanged === 1'b1) changeCount++;
  endtask

  // One compressed frame containing exactly one rising edge of the trigger match
  task automatic runFrame();
    applyStimulus(10, 100, 1'b0, 1'b0);
    applyStimulus(11, 100, 1'b0, 1'b0);
    applyStimulus(799, 479, 1'b0, 1'b0);
    applyStimulus(0, 480, 1'b0, 1'b0);
    applyStimulus(1, 480, 1'b0, 1'b0);
    applyStimulus(2, 480, 1'b0, 1'b0);
    applyStimulus(10, 500, 1'b0, 1'b0);
  endtask

  initial begin
    int autoExp[10];
    autoExp = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    totalChecks = 0;
    badChecks   = 0;
    tickCount   = 0;
    changeCount = 0;
    hCount  = 10'd10;
    vCount  = 10'd100;
    reqUp   = 1'b0;
    reqDown = 1'b0;
    autoEn  = 1'b0;

    $display("[TB] reset and tick width");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_looking_up", int'(lookingUp), 0);
    checkOutput("rst_frame_tick", int'(frameTick), 0);
    checkOutput("rst_pose_changed", int'(poseChanged), 0);
    rst = 1'b0;
    applyStimulus(799, 479, 1'b0, 1'b0);
    checkOutput("tick_before_match", int'(frameTick), 0);
    applyStimulus(0, 480, 1'b0, 1'b0);
    checkOutput("tick_after_match", int'(frameTick), 1);
    applyStimulus(1, 480, 1'b0, 1'b0);
    checkOutput("tick_one_wide", int'(frameTick), 0);
    applyStimulus(0, 480, 1'b0, 1'b0);
    applyStimulus(0, 480, 1'b0, 1'b0);
    checkOutput("tick_held_match", int'(frameTick), 0);
    applyStimulus(0, 480, 1'b0, 1'b0);
    checkOutput("tick_held_match2", int'(frameTick), 0);
    tickCount = 0;
    changeCount = 0;
    runFrame();
    runFrame();
    checkOutput("ticks_per_frame", tickCount, 2);
    checkOutput("idle_looking_up", int'(lookingUp), 0);
    checkOutput("idle_no_change", changeCount, 0);

    $display("[TB] manual up with timeout");
    changeCount = 0;
    applyStimulus(10, 100, 1'b1, 1'b0);
    checkOutput("armed_still_down", int'(lookingUp), 0);
    applyStimulus(799, 479, 1'b0, 1'b0);
    applyStimulus(0, 480, 1'b0, 1'b0);
    checkOutput("up_tick_seen", int'(frameTick), 1);
    checkOutput("up_not_yet", int'(lookingUp), 0);
    applyStimulus(1, 480, 1'b0, 1'b0);
    checkOutput("up_rise", int'(lookingUp), 1);
    checkOutput("up_rise_pulse", int'(poseChanged), 1);
    applyStimulus(2, 480, 1'b0, 1'b0);
    checkOutput("up_pulse_one_wide", int'(poseChanged), 0);
    runFrame();
    checkOutput("up_hold_frame1", int'(lookingUp), 1);
    runFrame();
    checkOutput("up_timeout", int'(lookingUp), 0);
    checkOutput("up_change_count", changeCount, 2);

    $display("[TB] automatic cycle");
    changeCount = 0;
    autoEn = 1'b1;
    for (int f = 0; f < 10; f++) begin
      runFrame();
      checkOutput($sformatf("auto_frame%0d", f), int'(lookingUp), autoExp[f]);
    end
    checkOutput("auto_change_count", changeCount, 4);
    autoEn = 1'b0;
    runFrame();

    $display("[TB] cancel and conflict");
    changeCount = 0;
    applyStimulus(10, 100, 1'b1, 1'b0);
    applyStimulus(10, 101, 1'b0, 1'b1);
    runFrame();
    checkOutput("cancel_up", int'(lookingUp), 0);
    applyStimulus(10, 100, 1'b1, 1'b1);
    runFrame();
    checkOutput("both_req_down", int'(lookingUp), 0);
    checkOutput("cancel_no_change", changeCount, 0);
    applyStimulus(10, 100, 1'b1, 1'b0);
    runFrame();
    checkOutput("cancel_setup_up", int'(lookingUp), 1);
    runFrame();
    changeCount = 0;
    applyStimulus(10, 100, 1'b0, 1'b1);
    applyStimulus(10, 101, 1'b1, 1'b0);
    runFrame();
    checkOutput("hold_restarted", int'(lookingUp), 1);
    runFrame();
    checkOutput("hold_restart_timeout", int'(lookingUp), 0);
    checkOutput("cancel_down_changes", changeCount, 1);

    $display("[TB] tick collision");
    changeCount = 0;
    applyStimulus(799, 479, 1'b0, 1'b0);
    applyStimulus(0, 480, 1'b0, 1'b0);
    checkOutput("coll_tick", int'(frameTick), 1);
    applyStimulus(1, 480, 1'b1, 1'b0);
    checkOutput("coll_no_change", int'(lookingUp), 0);
    applyStimulus(2, 480, 1'b0, 1'b0);
    checkOutput("coll_still_down", int'(lookingUp), 0);
    runFrame();
    checkOutput("coll_next_tick_up", int'(lookingUp), 1);
    checkOutput("coll_change_count", changeCount, 1);
    runFrame();
    runFrame();
    checkOutput("coll_back_down", int'(lookingUp), 0);

    $display("[TB] reset mid-hold");
    autoEn = 1'b1;
    applyStimulus(10, 100, 1'b1, 1'b0);
    runFrame();
    runFrame();
    checkOutput("mid_hold_up", int'(lookingUp), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_down", int'(lookingUp), 0);
    checkOutput("async_rst_pulse", int'(poseChanged), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_held_pulse", int'(poseChanged), 0);
    rst = 1'b0;
    changeCount = 0;
    runFrame();
    checkOutput("restart_frame0", int'(lookingUp), 0);
    runFrame();
    checkOutput("restart_frame1", int'(lookingUp), 0);
    runFrame();
    checkOutput("restart_frame2", int'(lookingUp), 1);
    checkOutput("restart_change_count", changeCount, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
